// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: stage strobe layout,
// one-hot stage encodings and fetch FSM state encodings.
package instruction_fetch_pkg;

   typedef logic [0:3] stage_t;

   localparam int STAGE_FETCH     = 0;
   localparam int STAGE_DECODE    = 1;
   localparam int STAGE_EXECUTE   = 2;
   localparam int STAGE_WRITEBACK = 3;

   // bit 0 of the ascending vector is the leftmost literal bit
   localparam stage_t STAGE_OH_FETCH     = 4'b1000;
   localparam stage_t STAGE_OH_WRITEBACK = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } fetch_state_t;

   function automatic logic stage_multihot(input stage_t s);
      int n;
      n = int'(s[STAGE_FETCH]) + int'(s[STAGE_DECODE])
        + int'(s[STAGE_EXECUTE]) + int'(s[STAGE_WRITEBACK]);
      return n > 1;
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Program memory read port: request/address out, acknowledge/data back.
interface instruction_fetch_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  mem_rd_req;
   logic [0:ADDR_WIDTH-1] mem_addr;
   logic                  mem_rd_ack;
   logic [0:DATA_WIDTH-1] mem_rd_data;

   modport master (output mem_rd_req, mem_addr, input mem_rd_ack, mem_rd_data);
   modport slave  (input mem_rd_req, mem_addr, output mem_rd_ack, mem_rd_data);
endinterface

// File: rtl/instruction_fetch.sv
// Fetches one multi-byte instruction per stage cycle and advances the PC on
// the writeback strobe.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for the FETCH strobe
// ST_FETCH | reading bytes, req and stall held high
// ST_DONE  | instr valid, waiting for the WRITEBACK strobe to move the PC
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int              ADDR_WIDTH  = 8,
   parameter int              DATA_WIDTH  = 8,
   parameter int              INSTR_BYTES = 4,
   parameter logic [0:ADDR_WIDTH-1] RESET_PC = '0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [0:3]                        is_stage,
   input  logic                              branch_en,
   input  logic [0:ADDR_WIDTH-1]             branch_target,
   instruction_fetch_if.master               mem,
   output logic [0:INSTR_BYTES*DATA_WIDTH-1] instr,
   output logic                              instr_valid,
   output logic [0:ADDR_WIDTH-1]             pc,
   output logic                              stall,
   output logic                              stage_err
);

   localparam int IDX_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
   localparam int INSTR_W = INSTR_BYTES * DATA_WIDTH;

   fetch_state_t              state_q, state_d;
   logic [0:ADDR_WIDTH-1]     pc_q, pc_d;
   logic [IDX_W-1:0]          byte_idx_q, byte_idx_d;
   logic [0:INSTR_W-1]        instr_q, instr_d;
   logic                      instr_valid_q, instr_valid_d;
   logic                      stage_err_q, stage_err_d;
   logic                      fetching;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         byte_idx_q    <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         stage_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         byte_idx_q    <= byte_idx_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         stage_err_q   <= stage_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      byte_idx_d    = byte_idx_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      stage_err_d   = stage_err_q | stage_multihot(is_stage);

      case (state_q)
         ST_IDLE: begin
            if (is_stage == STAGE_OH_FETCH) begin
               state_d       = ST_FETCH;
               instr_valid_d = 1'b0;
               byte_idx_d    = '0;
            end
         end
         ST_FETCH: begin
            if (mem.mem_rd_ack) begin
               instr_d[int'(byte_idx_q)*DATA_WIDTH +: DATA_WIDTH] = mem.mem_rd_data;
               if (byte_idx_q == IDX_W'(INSTR_BYTES - 1)) begin
                  state_d       = ST_DONE;
                  instr_valid_d = 1'b1;
                  byte_idx_d    = '0;
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            // a FETCH strobe here is ignored so the PC can never be skipped
            if (is_stage == STAGE_OH_WRITEBACK) begin
               pc_d    = branch_en ? branch_target : pc_q + ADDR_WIDTH'(INSTR_BYTES);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign fetching        = (state_q == ST_FETCH);
   assign mem.mem_rd_req  = fetching;
   assign mem.mem_addr    = pc_q + ADDR_WIDTH'(byte_idx_q);
   assign stall           = fetching;
   assign instr           = instr_q;
   assign instr_valid     = instr_valid_q;
   assign pc              = pc_q;
   assign stage_err       = stage_err_q;

endmodule
